instruction_fetch_unit: RTL and testbench

//   Supplies the multicycle CPU's instruction register: holds the PC and issues a
//   req/ack read to instruction memory. It returns the fetched word on instr_out with
//   a one-cycle ir_write strobe, which the IR samples as InstructionIn/IRWrite.
//   The control FSM requests each fetch with fetch_start.

---
 rtl/instruction_fetch_unit_if.sv | 29 ++
 rtl/instruction_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: control requests from the CPU FSM, the req/ack path to
// instruction memory, and the IR / status outputs. master = fetch unit side.
interface instruction_fetch_unit_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  fetch_start;
    logic                  pc_load;
    logic [ADDR_WIDTH-1:0] pc_in;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] instr_out;
    logic                  ir_write;
    logic [ADDR_WIDTH-1:0] pc_out;
    logic                  busy;
    logic                  fault;

    modport master (
        input  fetch_start, pc_load, pc_in, mem_ack, mem_rdata,
        output mem_req, mem_addr, instr_out, ir_write, pc_out, busy, fault
    );

    modport slave (
        output fetch_start, pc_load, pc_in, mem_ack, mem_rdata,
        input  mem_req, mem_addr, instr_out, ir_write, pc_out, busy, fault
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC and fetches one word per fetch_start over req/ack.
// Latency: mem_req one cycle after fetch_start, ir_write one cycle after ack; holds mem_req until ack or timeout.
module instruction_fetch_unit #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    instruction_fetch_unit_if.master   bus
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DELIVER = 2'd2,
        S_FAULT   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  mem_req_q, mem_req_d;
    logic                  ir_write_q, ir_write_d;
    logic                  busy_q, busy_d;
    logic                  fault_q, fault_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic [ADDR_WIDTH-1:0] fetch_addr;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        pend_vld_d = pend_vld_q;
        pend_pc_d  = pend_pc_q;
        tmo_cnt_d  = tmo_cnt_q;
        fetch_addr = bus.pc_load ? bus.pc_in : pc_q;

        case (state_q)
            S_IDLE: begin
                if (bus.pc_load) pc_d = bus.pc_in;
                if (bus.fetch_start) begin
                    if (fetch_addr[1:0] != 2'b00) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d    = S_REQ;
                        mem_addr_d = fetch_addr;
                        tmo_cnt_d  = '0;
                    end
                end
            end
            S_REQ: begin
                if (bus.pc_load) begin
                    pend_vld_d = 1'b1;
                    pend_pc_d  = bus.pc_in;
                end
                if (bus.mem_ack) begin
                    instr_d = bus.mem_rdata;
                    state_d = S_DELIVER;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (tmo_cnt_q == TMO_LAST) state_d   = S_FAULT;
                    else                       tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            S_DELIVER: begin
                // A load arriving in this very cycle is the newest target, so it beats the latched one.
                if (bus.pc_load)     pc_d = bus.pc_in;
                else if (pend_vld_q) pc_d = pend_pc_q;
                else                 pc_d = pc_q + ADDR_WIDTH'(4);
                pend_vld_d = 1'b0;
                state_d    = S_IDLE;
            end
            S_FAULT: begin
                if (bus.pc_load) begin
                    pc_d    = bus.pc_in;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered copies of the next state.
        mem_req_d  = (state_d == S_REQ);
        ir_write_d = (state_d == S_DELIVER);
        busy_d     = (state_d == S_REQ) || (state_d == S_DELIVER);
        fault_d    = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            mem_addr_q <= '0;
            instr_q    <= '0;
            mem_req_q  <= 1'b0;
            ir_write_q <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_pc_q  <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
            mem_req_q  <= mem_req_d;
            ir_write_q <= ir_write_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
            pend_vld_q <= pend_vld_d;
            pend_pc_q  <= pend_pc_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.instr_out = instr_q;
    assign bus.ir_write  = ir_write_q;
    assign bus.pc_out    = pc_q;
    assign bus.busy      = busy_q;
    assign bus.fault     = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: one DUT with a 15-cycle timeout, one with timeout disabled.
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifa ();
    instruction_fetch_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifb ();

    instruction_fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0), .TIMEOUT_CYCLES(15))
        dut (.clk(clk), .rst_n(rst_n), .bus(ifa));
    instruction_fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0), .TIMEOUT_CYCLES(0))
        dut_nt (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int checks = 0;
    int errors = 0;
    int ir_cnt = 0;
    int req_cnt = 0;

    always @(posedge clk) begin
        if (ifa.ir_write === 1'b1) ir_cnt <= ir_cnt + 1;
        if (ifa.mem_req === 1'b1) req_cnt <= req_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        ifa.fetch_start = 0; ifa.pc_load = 0; ifa.pc_in = '0; ifa.mem_ack = 0; ifa.mem_rdata = '0;
        ifb.fetch_start = 0; ifb.pc_load = 0; ifb.pc_in = '0; ifb.mem_ack = 0; ifb.mem_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        checks++; if (ifa.pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", ifa.pc_out, 32'h0); end
        checks++; if (ifa.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", ifa.mem_req); end
        checks++; if (ifa.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", ifa.mem_addr); end
        checks++; if (ifa.instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", ifa.instr_out); end
        checks++; if ({ifa.ir_write, ifa.busy, ifa.fault} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {ifa.ir_write, ifa.busy, ifa.fault}); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_basic_fetch();
        int base;
        base = ir_cnt;
        ifa.fetch_start = 1;
        @(negedge clk);
        checks++; if ({ifa.mem_req, ifa.busy, ifa.ir_write} !== 3'b110) begin errors++; $display("FAIL basic_req: got %b want 110", {ifa.mem_req, ifa.busy, ifa.ir_write}); end
        checks++; if (ifa.mem_addr !== 32'h0) begin errors++; $display("FAIL basic_addr: got %h want 0", ifa.mem_addr); end
        ifa.fetch_start = 0; ifa.mem_ack = 1; ifa.mem_rdata = 32'h8C010004;
        @(negedge clk);
        ifa.mem_ack = 0;
        checks++; if ({ifa.ir_write, ifa.mem_req} !== 2'b10) begin errors++; $display("FAIL basic_deliver: got %b want 10", {ifa.ir_write, ifa.mem_req}); end
        checks++; if (ifa.instr_out !== 32'h8C010004) begin errors++; $display("FAIL basic_instr: got %h want 8c010004", ifa.instr_out); end
        checks++; if (ifa.pc_out !== 32'h0) begin errors++; $display("FAIL basic_pc_early: got %h want 0", ifa.pc_out); end
        @(negedge clk);
        checks++; if (ifa.pc_out !== 32'h4) begin errors++; $display("FAIL basic_pc: got %h want 4", ifa.pc_out); end
        checks++; if ({ifa.ir_write, ifa.busy} !== 2'b00) begin errors++; $display("FAIL basic_idle: got %b want 00", {ifa.ir_write, ifa.busy}); end
        checks++; if (ir_cnt - base !== 1) begin errors++; $display("FAIL basic_ir_count: got %0d want 1", ir_cnt - base); end
    endtask

    task automatic test_delayed_ack();
        int base;
        int good;
        base = ir_cnt; good = 0;
        ifa.pc_load = 1; ifa.pc_in = 32'h10;
        @(negedge clk);
        ifa.pc_load = 0; ifa.fetch_start = 1;
        @(negedge clk);
        ifa.fetch_start = 0;
        for (int i = 0; i < 4; i++) begin
            if (ifa.mem_req === 1'b1 && ifa.mem_addr === 32'h10) good++;
            if (i == 3) begin ifa.mem_ack = 1; ifa.mem_rdata = 32'h00A00093; end
            @(negedge clk);
        end
        ifa.mem_ack = 0;
        checks++; if (good !== 4) begin errors++; $display("FAIL delay_req_steady: got %0d cycles want 4", good); end
        checks++; if (ifa.instr_out !== 32'h00A00093) begin errors++; $display("FAIL delay_instr: got %h want 00a00093", ifa.instr_out); end
        @(negedge clk);
        checks++; if (ifa.pc_out !== 32'h14) begin errors++; $display("FAIL delay_pc: got %h want 14", ifa.pc_out); end
        checks++; if (ir_cnt - base !== 1) begin errors++; $display("FAIL delay_ir_count: got %0d want 1", ir_cnt - base); end
    endtask

    task automatic test_pending_load();
        ifa.fetch_start = 1;
        @(negedge clk);
        ifa.fetch_start = 0;
        checks++; if (ifa.mem_addr !== 32'h14) begin errors++; $display("FAIL pend_addr: got %h want 14", ifa.mem_addr); end
        ifa.pc_load = 1; ifa.pc_in = 32'h40;
        @(negedge clk);
        ifa.pc_load = 0; ifa.pc_in = '0; ifa.mem_ack = 1; ifa.mem_rdata = 32'h11111111;
        @(negedge clk);
        ifa.mem_ack = 0;
        @(negedge clk);
        checks++; if (ifa.pc_out !== 32'h40) begin errors++; $display("FAIL pend_pc: got %h want 40", ifa.pc_out); end
        ifa.pc_load = 1; ifa.pc_in = 32'h80; ifa.fetch_start = 1;
        @(negedge clk);
        ifa.pc_load = 0; ifa.fetch_start = 0;
        checks++; if ({ifa.mem_req, ifa.mem_addr} !== {1'b1, 32'h80}) begin errors++; $display("FAIL load_fetch_addr: got %b/%h want 1/80", ifa.mem_req, ifa.mem_addr); end
        ifa.mem_ack = 1; ifa.mem_rdata = 32'h22222222;
        @(negedge clk);
        ifa.mem_ack = 0;
        @(negedge clk);
        checks++; if (ifa.pc_out !== 32'h84) begin errors++; $display("FAIL load_fetch_pc: got %h want 84", ifa.pc_out); end
    endtask

    task automatic test_misaligned();
        int base;
        base = req_cnt;
        ifa.pc_load = 1; ifa.pc_in = 32'h6;
        @(negedge clk);
        ifa.pc_load = 0; ifa.fetch_start = 1;
        @(negedge clk);
        checks++; if ({ifa.fault, ifa.busy, ifa.mem_req} !== 3'b100) begin errors++; $display("FAIL misalign_fault: got %b want 100", {ifa.fault, ifa.busy, ifa.mem_req}); end
        repeat (2) @(negedge clk);
        checks++; if (req_cnt - base !== 0 || ifa.fault !== 1'b1) begin errors++; $display("FAIL misalign_no_req: got reqs=%0d fault=%b want 0/1", req_cnt - base, ifa.fault); end
        ifa.fetch_start = 0; ifa.pc_load = 1; ifa.pc_in = 32'h8;
        @(negedge clk);
        ifa.pc_load = 0;
        checks++; if ({ifa.fault, ifa.busy, ifa.pc_out} !== {2'b00, 32'h8}) begin errors++; $display("FAIL misalign_recover: got %b%b/%h want 00/8", ifa.fault, ifa.busy, ifa.pc_out); end
        ifa.fetch_start = 1;
        @(negedge clk);
        ifa.fetch_start = 0;
        checks++; if ({ifa.mem_req, ifa.mem_addr} !== {1'b1, 32'h8}) begin errors++; $display("FAIL recover_fetch: got %b/%h want 1/8", ifa.mem_req, ifa.mem_addr); end
        ifa.mem_ack = 1; ifa.mem_rdata = 32'h33333333;
        @(negedge clk);
        ifa.mem_ack = 0;
        @(negedge clk);
        checks++; if (ifa.pc_out !== 32'hC) begin errors++; $display("FAIL recover_pc: got %h want c", ifa.pc_out); end
    endtask

    task automatic test_timeout();
        int hold;
        hold = 0;
        ifa.fetch_start = 1; ifb.fetch_start = 1;
        @(negedge clk);
        ifa.fetch_start = 0; ifb.fetch_start = 0;
        for (int i = 0; i < 15; i++) begin
            if (ifa.mem_req === 1'b1 && ifa.fault === 1'b0) hold++;
            @(negedge clk);
        end
        checks++; if (hold !== 15) begin errors++; $display("FAIL timeout_hold: got %0d req cycles want 15", hold); end
        checks++; if ({ifa.mem_req, ifa.fault, ifa.busy} !== 3'b010) begin errors++; $display("FAIL timeout_fault: got %b want 010", {ifa.mem_req, ifa.fault, ifa.busy}); end
        repeat (86) @(negedge clk);
        checks++; if ({ifb.mem_req, ifb.busy, ifb.fault} !== 3'b110) begin errors++; $display("FAIL no_timeout_wait: got %b want 110", {ifb.mem_req, ifb.busy, ifb.fault}); end
        ifa.pc_load = 1; ifa.pc_in = 32'h20;
        @(negedge clk);
        ifa.pc_load = 0;
        checks++; if ({ifa.fault, ifa.pc_out} !== {1'b0, 32'h20}) begin errors++; $display("FAIL timeout_recover: got %b/%h want 0/20", ifa.fault, ifa.pc_out); end
    endtask

    task automatic test_reset_mid_req();
        ifa.fetch_start = 1;
        @(negedge clk);
        ifa.fetch_start = 0;
        checks++; if (ifa.mem_req !== 1'b1) begin errors++; $display("FAIL rstreq_pre: got %b want 1", ifa.mem_req); end
        rst_n = 0;
        #1;
        checks++; if ({ifa.mem_req, ifa.busy, ifa.pc_out} !== {2'b00, 32'h0}) begin errors++; $display("FAIL rstreq_drop: got %b%b/%h want 00/0", ifa.mem_req, ifa.busy, ifa.pc_out); end
        ifa.mem_ack = 1; ifa.mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        ifa.mem_ack = 0;
        checks++; if ({ifa.ir_write, ifa.mem_req, ifa.instr_out} !== {2'b00, 32'h0}) begin errors++; $display("FAIL late_ack: got %b%b/%h want 00/0", ifa.ir_write, ifa.mem_req, ifa.instr_out); end
    endtask

    task automatic test_pc_wrap();
        ifa.pc_load = 1; ifa.pc_in = 32'hFFFFFFFC; ifa.fetch_start = 1;
        @(negedge clk);
        ifa.pc_load = 0; ifa.fetch_start = 0;
        checks++; if (ifa.mem_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_addr: got %h want fffffffc", ifa.mem_addr); end
        ifa.mem_ack = 1; ifa.mem_rdata = 32'h12345678;
        @(negedge clk);
        ifa.mem_ack = 0;
        @(negedge clk);
        checks++; if (ifa.pc_out !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", ifa.pc_out); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_delayed_ack();
        test_pending_load();
        test_misaligned();
        test_timeout();
        test_reset_mid_req();
        test_pc_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
